aes256_inv_key_scheduler: RTL

AES256_INV_KEY_SCHEDULER -- requirements
Module: aes256_inv_key_scheduler

---
 rtl/aes256_inv_key_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/aes256_inv_key_scheduler.sv
// AES-256 decryption key scheduler: expands forward to RK14, then walks back to RK0
// one key per handshake, reusing the same four S-boxes for both directions.

module aes_sbox (
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = '0;
        aa  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
    always_comb begin
        sq  = in_byte_i;
        inv = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign out_byte_o = inv
                      ^ {inv[6:0], inv[7]}
                      ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]}
                      ^ 8'h63;

endmodule

module aes256_inv_key_scheduler #(
    parameter bit INPUT_IS_FINAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [255:0] key,
    output logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_key_idx,
    output logic         round_key_valid,
    input  logic         round_key_ready,
    output logic         round_key_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        EMIT
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] p_q, p_d;
    logic [127:0] q_q, q_d;
    logic [3:0]   n_q, n_d;

    logic         emit;
    logic [3:0]   step;
    logic [31:0]  g_x;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic [7:0]   rcon;
    logic [31:0]  g_w;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;

    assign emit = (state_q == EMIT);

    // Forward step n+1 keys off Q.w4; inverse step n keys off P.w4 (RK_{n-1}).
    assign step    = emit ? n_q : n_q + 4'd1;
    assign g_x     = emit ? p_q[31:0] : q_q[31:0];
    assign sbox_in = step[0] ? g_x : {g_x[23:0], g_x[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte_i  (sbox_in[8*gi +: 8]),
            .out_byte_o (sbox_out[8*gi +: 8])
        );
    end

    always_comb begin
        rcon = 8'h00;
        if (!step[0]) begin
            case (step[3:1])
                3'd1:    rcon = 8'h01;
                3'd2:    rcon = 8'h02;
                3'd3:    rcon = 8'h04;
                3'd4:    rcon = 8'h08;
                3'd5:    rcon = 8'h10;
                3'd6:    rcon = 8'h20;
                3'd7:    rcon = 8'h40;
                default: rcon = 8'h00;
            endcase
        end
    end

    assign g_w = sbox_out ^ {rcon, 24'h000000};

    always_comb begin
        fwd_key[127:96] = p_q[127:96] ^ g_w;
        fwd_key[95:64]  = p_q[95:64]  ^ fwd_key[127:96];
        fwd_key[63:32]  = p_q[63:32]  ^ fwd_key[95:64];
        fwd_key[31:0]   = p_q[31:0]   ^ fwd_key[63:32];
    end

    assign inv_key = {q_q[127:96] ^ g_w,
                      q_q[95:64]  ^ q_q[127:96],
                      q_q[63:32]  ^ q_q[95:64],
                      q_q[31:0]   ^ q_q[63:32]};

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    p_d = key[255:128];
                    q_d = key[127:0];
                    if (INPUT_IS_FINAL) begin
                        state_d = EMIT;
                        n_d     = 4'd14;
                    end else begin
                        state_d = EXPAND;
                        n_d     = 4'd1;
                    end
                end
            end
            EXPAND: begin
                p_d = q_q;
                q_d = fwd_key;
                n_d = n_q + 4'd1;
                if (n_q == 4'd13) state_d = EMIT;
            end
            EMIT: begin
                if (round_key_ready) begin
                    if (n_q >= 4'd2) begin
                        p_d = inv_key;
                        q_d = p_q;
                        n_d = n_q - 4'd1;
                    end else if (n_q == 4'd1) begin
                        q_d = p_q;
                        n_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            n_q     <= n_d;
        end
    end

    assign key_ready       = (state_q == IDLE) && !rst;
    assign round_key_valid = emit;
    assign round_key       = emit ? q_q : '0;
    assign round_key_idx   = emit ? n_q : '0;
    assign round_key_last  = emit && (n_q == 4'd0);
    assign busy            = (state_q == EXPAND) || emit;

endmodule
